water_level_ctrl: RTL
=====================

WATER_LEVEL_CTRL -- requirements
Module: water_level_ctrl

Interface
REQ-001 Parameter SENSOR_W, default 8, width of the sensor level code.
REQ-002 Parameter FULL_TH, default 200, level code at or above which the tub is full.
REQ-003 Parameter HYST, default 16, top-up hysteresis; top-up level is FULL_TH-HYST.
REQ-004 Parameter EMPTY_TH, default 8, level code at or below which the tub is empty.
REQ-005 Parameter FILT_N, default 4, number of consecutive qualifying valid samples before a level decision.
REQ-006 Parameter TIMEOUT, default 1000, maximum cycles allowed in FILLING or DRAINING.
REQ-007 Ports, in the form name direction width meaning:
- clk in 1: single clock, rising edge.
- rst in 1: asynchronous, active-low reset.
- fill_req in 1: level request from the washing_machine controller.
- drain_req in 1: drain request.
- clear_fault in 1: single-cycle fault acknowledge.
- sensor_valid in 1: sensor sample strobe.
- sensor_level in SENSOR_W: raw level code.
- fill_valve out 1: fill valve drive.
- drain_pump out 1: drain pump drive.
- water_level out 1: filtered full indication, which feeds washing_machine.water_level.
- empty out 1: filtered empty indication.
- fault out 1: timeout or overflow fault.

Function
REQ-008 The block SHALL implement the states IDLE, FILLING, FULL, DRAINING and FAULT, with registered Moore outputs.
REQ-009 The filter SHALL count only cycles where sensor_valid=1.
- A valid sample that does not qualify resets the count to 0.
- Cycles with sensor_valid=0 hold the count.
- The count saturates at FILT_N.
- The count is cleared on every state change.
REQ-010 In IDLE, all outputs SHALL be 0 except empty, which holds its last value.
- drain_req=1 goes to DRAINING.
- Otherwise fill_req=1 goes to FILLING.
- drain_req has priority when both are high.
REQ-011 In FILLING, fill_valve SHALL be 1 and the timer SHALL increment every cycle.
- FILT_N qualifying samples (level>=FULL_TH) go to FULL.
- Timer reaching TIMEOUT goes to FAULT.
- drain_req=1 goes to DRAINING.
- fill_req=0 (with no drain_req) goes to IDLE.
REQ-012 In FULL, water_level SHALL be 1 and both valves SHALL be 0.
- FILT_N qualifying samples (level<FULL_TH-HYST) while fill_req=1 go to FILLING (top-up); water_level drops to 0.
- drain_req=1 goes to DRAINING.
- fill_req=0 keeps the state FULL.
REQ-013 In DRAINING, drain_pump SHALL be 1, water_level SHALL be 0 and the timer SHALL run.
- FILT_N qualifying samples (level<=EMPTY_TH) go to IDLE with empty=1.
- Timer reaching TIMEOUT goes to FAULT.
- fill_req is ignored in this state.
REQ-014 empty SHALL clear on entry to FILLING.
REQ-015 In FAULT, fault SHALL be 1 and both valves SHALL be 0.
- clear_fault=1 goes to IDLE.
- All other inputs are ignored.
REQ-016 The timer SHALL clear on every state change.
REQ-017 The timer width SHALL be $clog2(TIMEOUT+1) bits and the timer SHALL never wrap.
REQ-018 Latency from the FILT_N-th qualifying sample edge to the output change SHALL be exactly 1 cycle.
REQ-019 fill_valve and drain_pump SHALL never be 1 in the same cycle.

Reset
REQ-020 rst=0 SHALL immediately force IDLE and drive fill_valve=0, drain_pump=0, water_level=0, fault=0, empty=0, filter count 0 and timer 0, regardless of clk.
REQ-021 Reset asserted mid-FILLING or mid-DRAINING SHALL drop both valves asynchronously, with no one-cycle delay.
REQ-022 After rst deasserts, the first state transition SHALL occur at the first rising clk edge.

Configuration
REQ-023 With macro WLC_OVERFLOW_EN defined, an overflow check SHALL be active in every state except FAULT.
- Parameter OVF_TH defaults to 240.
- A single valid sample with level>=OVF_TH forces FAULT.
- In FAULT, drain_pump=1 until a valid sample with level<=EMPTY_TH is seen, then drain_pump=0.
REQ-024 Without WLC_OVERFLOW_EN, the block SHALL have no OVF_TH logic, and drain_pump SHALL be 0 in FAULT.

Verification
REQ-025 The bench SHALL cover the following directed scenarios:
- Fill: fill_req=1, level 210 valid every cycle -> fill_valve=1 from cycle 1; water_level=1 one cycle after the 4th sample; fill_valve=0 in the same cycle.
- Top-up: in FULL with fill_req=1, four samples of 180 -> FILLING; water_level=0; fill_valve=1. Four samples of 190 -> stays FULL.
- Drain: drain_req and fill_req both high from IDLE -> DRAINING. Four samples of 5 -> IDLE with empty=1 and drain_pump=0.
- Timeout: fill_req=1, level stuck at 50 -> fault=1 and fill_valve=0 after 1000 cycles. clear_fault pulse -> IDLE with fault=0.
- Reset: rst=0 mid-clock-period during FILLING -> fill_valve=0 before the next edge; all outputs 0.
- Overflow: with WLC_OVERFLOW_EN, one sample of 245 in FULL -> fault=1, drain_pump=1 until a sample of 5. Without the macro -> remains FULL.

Source files
------------

// File: rtl/water_level_ctrl.sv
// -----------------------------------------------------------------------------
// water_level_ctrl
//
// Tub water-level controller for the washing machine. It drives the fill valve
// and the drain pump from a noisy level sensor. Level decisions are debounced
// by a filter that needs FILT_N consecutive qualifying valid samples. Time
// spent filling or draining is bounded by a timeout that traps into FAULT.
//
// States: IDLE, FILLING, FULL, DRAINING, FAULT. All outputs are registered
// Moore outputs. They are decoded from the next state, so they change on the
// same edge as the state register.
//
// Ports:
//   clk           in   1         single clock, rising edge
//   rst           in   1         asynchronous, active-low reset
//   fill_req      in   1         level request from the machine controller
//   drain_req     in   1         drain request (wins over fill_req)
//   clear_fault   in   1         single-cycle fault acknowledge
//   sensor_valid  in   1         sensor sample strobe
//   sensor_level  in   SENSOR_W  raw level code
//   fill_valve    out  1         fill valve drive
//   drain_pump    out  1         drain pump drive
//   water_level   out  1         filtered "tub full" indication
//   empty         out  1         filtered "tub empty" indication
//   fault         out  1         timeout / overflow fault
//
// Build option:
//   WLC_OVERFLOW_EN  When defined, a valid sample at or above OVF_TH forces
//                    FAULT from any other state. While in FAULT the pump then
//                    runs until a valid sample at or below EMPTY_TH is seen.
//                    When undefined, there is no overflow logic and the pump
//                    stays off in FAULT.
// -----------------------------------------------------------------------------
module water_level_ctrl #(
    parameter int unsigned SENSOR_W = 8,
    parameter int unsigned FULL_TH  = 200,
    parameter int unsigned HYST     = 16,
    parameter int unsigned EMPTY_TH = 8,
    parameter int unsigned FILT_N   = 4,
    parameter int unsigned TIMEOUT  = 1000
`ifdef WLC_OVERFLOW_EN
    ,
    parameter int unsigned OVF_TH   = 240
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fill_req,
    input  logic                drain_req,
    input  logic                clear_fault,
    input  logic                sensor_valid,
    input  logic [SENSOR_W-1:0] sensor_level,
    output logic                fill_valve,
    output logic                drain_pump,
    output logic                water_level,
    output logic                empty,
    output logic                fault
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int unsigned CNT_W = $clog2(FILT_N + 1);
    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [SENSOR_W-1:0] FULL_LVL  = SENSOR_W'(FULL_TH);
    localparam logic [SENSOR_W-1:0] TOPUP_LVL = SENSOR_W'(FULL_TH - HYST);
    localparam logic [SENSOR_W-1:0] EMPTY_LVL = SENSOR_W'(EMPTY_TH);

    localparam logic [CNT_W-1:0] FILT_MAX  = CNT_W'(FILT_N);
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_N - 1);
    localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_FILLING  = 3'd1;
    localparam logic [2:0] S_FULL     = 3'd2;
    localparam logic [2:0] S_DRAINING = 3'd3;
    localparam logic [2:0] S_FAULT    = 3'd4;

    // -------------------------------------------------------------------------
    // Signals
    // -------------------------------------------------------------------------
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_step;
    logic [TMR_W-1:0] tmr_q, tmr_d;

    logic             qual;          // current sample meets this state's level test
    logic             filt_hit;      // this sample is the FILT_N-th qualifying one
    logic             timed_state;   // timer runs only while filling/draining
    logic             tmr_expired;   // timer reaches TIMEOUT at this edge
    logic             state_change;

    logic             fill_valve_q, fill_valve_d;
    logic             drain_pump_q, drain_pump_d;
    logic             water_level_q, water_level_d;
    logic             empty_q, empty_d;
    logic             fault_q, fault_d;

`ifdef WLC_OVERFLOW_EN
    localparam logic [SENSOR_W-1:0] OVF_LVL = SENSOR_W'(OVF_TH);

    logic ovf_hit;                   // overflow sample outside FAULT
    logic ovf_drain_q, ovf_drain_d;  // pump still emptying the tub in FAULT

    assign ovf_hit = sensor_valid && (sensor_level >= OVF_LVL) && (state_q != S_FAULT);
`endif

    // -------------------------------------------------------------------------
    // Level filter
    // The level test depends on the state. In IDLE and FAULT nothing
    // qualifies, so any valid sample there holds the count at 0.
    // -------------------------------------------------------------------------
    // NOTE: every combinational output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        qual = 1'b0;
        case (state_q)
            S_FILLING:  qual = (sensor_level >= FULL_LVL);
            S_FULL:     qual = (sensor_level <  TOPUP_LVL);
            S_DRAINING: qual = (sensor_level <= EMPTY_LVL);
            default:    qual = 1'b0;
        endcase
    end

    always_comb begin
        cnt_step = cnt_q;
        if (sensor_valid) begin
            if (!qual) begin
                cnt_step = '0;
            end else if (cnt_q != FILT_MAX) begin
                cnt_step = cnt_q + CNT_W'(1);
            end
        end
    end

    // The decision fires on the sample that brings the count to FILT_N. A
    // saturated count still needs a fresh qualifying sample to act.
    assign filt_hit = sensor_valid && qual && (cnt_q >= FILT_LAST);

    // -------------------------------------------------------------------------
    // Timeout timer
    // -------------------------------------------------------------------------
    assign timed_state = (state_q == S_FILLING) || (state_q == S_DRAINING);
    assign tmr_expired = timed_state && (tmr_q >= TMR_LAST);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (drain_req) begin
                    state_d = S_DRAINING;
                end else if (fill_req) begin
                    state_d = S_FILLING;
                end
            end
            S_FILLING: begin
                if (filt_hit) begin
                    state_d = S_FULL;
                end else if (tmr_expired) begin
                    state_d = S_FAULT;
                end else if (drain_req) begin
                    state_d = S_DRAINING;
                end else if (!fill_req) begin
                    state_d = S_IDLE;
                end
            end
            S_FULL: begin
                // Draining wins over a top-up. Without fill_req the tub
                // just sits full.
                if (drain_req) begin
                    state_d = S_DRAINING;
                end else if (filt_hit && fill_req) begin
                    state_d = S_FILLING;
                end
            end
            S_DRAINING: begin
                // fill_req is deliberately ignored until the tub is empty.
                if (filt_hit) begin
                    state_d = S_IDLE;
                end else if (tmr_expired) begin
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                if (clear_fault) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef WLC_OVERFLOW_EN
        // Overflow is a safety trap and overrides every other transition.
        if (ovf_hit) begin
            state_d = S_FAULT;
        end
`endif
    end

    assign state_change = (state_d != state_q);

    // The filter and the timer both restart on every state change.
    assign cnt_d = state_change ? '0 : cnt_step;

    always_comb begin
        tmr_d = '0;
        if (timed_state && !state_change) begin
            // Saturate rather than wrap. A wrapped timer would hide a timeout.
            tmr_d = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + TMR_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Output decode from the next state
    // -------------------------------------------------------------------------
`ifdef WLC_OVERFLOW_EN
    always_comb begin
        ovf_drain_d = ovf_drain_q;
        if (state_d == S_FAULT && state_q != S_FAULT) begin
            ovf_drain_d = 1'b1;
        end else if (state_q == S_FAULT && sensor_valid && (sensor_level <= EMPTY_LVL)) begin
            ovf_drain_d = 1'b0;
        end
    end
`endif

    always_comb begin
        fill_valve_d  = (state_d == S_FILLING);
        water_level_d = (state_d == S_FULL);
        fault_d       = (state_d == S_FAULT);
`ifdef WLC_OVERFLOW_EN
        drain_pump_d  = (state_d == S_DRAINING) || ((state_d == S_FAULT) && ovf_drain_d);
`else
        drain_pump_d  = (state_d == S_DRAINING);
`endif
        // empty is sticky. It is set only by a completed drain and is
        // cleared when filling starts.
        empty_d = empty_q;
        if (state_q == S_DRAINING && state_d == S_IDLE) begin
            empty_d = 1'b1;
        end else if (state_d == S_FILLING && state_q != S_FILLING) begin
            empty_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // The outputs are flops on the async reset, so asserting rst drops both
    // valves at once, without waiting for a clock edge.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments, so every flop
    // samples pre-edge values no matter the order the blocks evaluate in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            tmr_q         <= '0;
            fill_valve_q  <= 1'b0;
            drain_pump_q  <= 1'b0;
            water_level_q <= 1'b0;
            empty_q       <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tmr_q         <= tmr_d;
            fill_valve_q  <= fill_valve_d;
            drain_pump_q  <= drain_pump_d;
            water_level_q <= water_level_d;
            empty_q       <= empty_d;
            fault_q       <= fault_d;
        end
    end

`ifdef WLC_OVERFLOW_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_drain_q <= 1'b0;
        end else begin
            ovf_drain_q <= ovf_drain_d;
        end
    end
`endif

    assign fill_valve  = fill_valve_q;
    assign drain_pump  = drain_pump_q;
    assign water_level = water_level_q;
    assign empty       = empty_q;
    assign fault       = fault_q;

endmodule
